cam_frame_capture: RTL and testbench
====================================

// Module: cam_frame_capture
// PURPOSE
//  Parametrised camera front end for OV7670-style byte streams, running entirely in the system Clk domain.
//  Cam_pclk is sampled and edge-detected; the sampled pixel clock is not used as a clock.
//  Frames are framed on vsync/href. Byte pairs are packed into RGB565 pixels.
//  An optional keystream XOR is applied per a mode/split-column setting.
//  Pixels go out as a linear-address write stream to video memory (VRAM banks or SRAM arbiter).
// PARAMETERS
//  H_ACTIVE     640  pixels per line written; extra pixels in a line are dropped
//  V_ACTIVE     240  lines per frame written; later lines are dropped
//  ADDR_W       18   width of Wr_addr; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE
//  SYNC_STAGES  2    synchroniser depth for Cam_pclk/vsync/href/data (>=2)
// PORTS
//  Clk        in   1       system clock; must be >= 4x Cam_pclk frequency
//  Reset      in   1       synchronous, active-high reset
//  Run        in   1       capture enable level
//  Cam_pclk   in   1       camera pixel clock, sampled as data
//  Cam_vsync  in   1       camera frame sync, active high
//  Cam_href   in   1       camera line-valid
//  Cam_data   in   8       camera byte
//  Mode       in   2       0 bypass, 1 encrypt all, 2 encrypt cols >= Split_col, 3 write black
//  Split_col  in   10      first encrypted column in mode 2
//  Key_data   in   16      keystream word, consumed per pixel
//  Key_req    out  1       1-cycle pulse: a first byte was latched, keystream word requested
//  Wr_en      out  1       1-cycle write strobe
//  Wr_addr    out  ADDR_W  row*H_ACTIVE+col
//  Wr_data    out  16      RGB565 pixel (after XOR/black)
//  Frame_done out  1       1-cycle pulse at end of captured frame
//  Line_err   out  1       sticky: overlong line or odd byte count seen; cleared on entering WAIT_VS_HI
//  Pix_count  out  20      pixels written in current frame
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; row/col/byte phase 0.
//  Input sync: pclk/vsync/href/data pass through SYNC_STAGES flops as one aligned bundle.
//  - pix_stb = synced pclk rising edge. All framing is evaluated only on pix_stb.
//  FSM: IDLE -Run-> WAIT_VS_HI -vsync=1-> WAIT_VS_LO -vsync=0-> CAPTURE.
//  - CAPTURE -vsync=1-> WAIT_VS_LO; Frame_done pulses that cycle.
//  - Run=0 in any state -> IDLE next Clk; Wr_en is 0 from that cycle.
//  - Run=0 has priority over all other transitions.
//  - Entering WAIT_VS_HI clears row, col, byte phase, Pix_count and Line_err.
//  - Entering WAIT_VS_LO from CAPTURE clears row, col and Pix_count only.
//  Pixel assembly (CAPTURE, href=1, pix_stb):
//  - Phase 0 latches hi byte and pulses Key_req.
//  - Phase 1 forms {hi,lo}.
//  - Wr_en is asserted the Clk after the phase-1 pix_stb, with Wr_addr/Wr_data valid in the same cycle.
//  Key_data: sampled on the phase-1 pix_stb cycle. The supplier must present it within 2 Clk of Key_req.
//  Data by mode: 0 -> {hi,lo}; 1 -> {hi,lo}^Key_data; 2 -> XOR only if col >= Split_col; 3 -> 16'h0000.
//  Address: kept incrementally as line_base + col (no multiplier). line_base += H_ACTIVE per written row.
//  Col: increments after each pixel. Writes are suppressed when col >= H_ACTIVE; the first such pixel sets Line_err.
//  Row: href falling edge ends a line.
//  - If the line had >= 1 pixel: row++, col=0.
//  - If byte phase was 1 (odd byte count): the pending byte is discarded, phase=0, Line_err set.
//  - Rows >= V_ACTIVE: no Wr_en and no Key_req, but counters keep running; nothing wraps into address 0.
//  Pix_count increments with every Wr_en and saturates at 2**20-1.
//  vsync rising mid-line ends the frame; a partial pixel is discarded without Line_err.
//  Simultaneous Run=0 and Wr_en-due: the write is dropped.
// TESTING
//  1. Reset, Run=1, 1 frame of 240 lines x 640 px (Mode 0, byte pairs 0xF8,0x00) -> 153600 writes of 16'hF800, addr 0..153599 in order, Frame_done once, Line_err=0, Pix_count=153600.
//  2. Mode 2, Split_col=320, Key_data=16'hFFFF, pixel 16'h1234 -> cols 0..319 write 16'h1234, cols 320..639 write 16'hEDCB.
//  3. Line of 642 px then normal line -> 640 writes on line 0, Line_err=1, line 1 starts at addr 640.
//  4. href drops after 3 bytes -> exactly 1 write, Line_err=1, next line pixel 0 byte-aligned correctly.
//  5. 260 lines sent -> last write addr 153599; no Wr_en during lines 240..259.
//  6. Assert Reset mid-line (row 10, col 100) -> all outputs 0 next Clk; capture resumes only after a full vsync high->low sequence.

Source files
------------

// File: rtl/cam_frame_capture.sv
// Camera byte-stream front end: samples an OV7670-style bus in the Clk domain, frames on
// vsync/href, packs RGB565 pixels, optionally XORs a keystream and emits linear VRAM writes.
module cam_frame_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Cam_pclk,
  input  logic              Cam_vsync,
  input  logic              Cam_href,
  input  logic [7:0]        Cam_data,
  input  logic [1:0]        Mode,
  input  logic [9:0]        Split_col,
  input  logic [15:0]       Key_data,
  output logic              Key_req,
  output logic              Wr_en,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [15:0]       Wr_data,
  output logic              Frame_done,
  output logic              Line_err,
  output logic [19:0]       Pix_count
);

  localparam int unsigned BusW = 11;
  localparam logic [10:0]       HLim  = 11'(H_ACTIVE);
  localparam logic [15:0]       VLim  = 16'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HStep = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitVsHi, StWaitVsLo, StCapture} state_e;

  state_e state_q, state_d;

  logic [BusW-1:0]   sync_q [SYNC_STAGES];
  logic [BusW-1:0]   s_bus;
  logic              s_pclk, s_vsync, s_href;
  logic [7:0]        s_data;
  logic              pclk_prev_q, href_prev_q;
  logic              pix_stb;

  logic [10:0]       col_q;
  logic [15:0]       row_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              wr_en_q, key_req_q, frame_done_q, line_err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic [19:0]       pix_count_q;

  logic              frame_end, enter_wait_hi, in_line;
  logic              byte_stb, line_end, row_ok, col_ok, write_due;
  logic [15:0]       pixel, pixel_out;

  // The whole camera bus goes through the same flop chain so pclk, syncs and data stay aligned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {Cam_pclk, Cam_vsync, Cam_href, Cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_bus   = sync_q[SYNC_STAGES-1];
  assign s_pclk  = s_bus[10];
  assign s_vsync = s_bus[9];
  assign s_href  = s_bus[8];
  assign s_data  = s_bus[7:0];
  assign pix_stb = s_pclk & ~pclk_prev_q;

  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    if (!Run) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StWaitVsHi;
        StWaitVsHi: if (pix_stb && s_vsync) state_d = StWaitVsLo;
        StWaitVsLo: if (pix_stb && !s_vsync) state_d = StCapture;
        StCapture: begin
          if (pix_stb && s_vsync) begin
            state_d   = StWaitVsLo;
            frame_end = 1'b1;
          end
        end
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    enter_wait_hi = (state_d == StWaitVsHi) && (state_q != StWaitVsHi);
    // Pixel work only happens when neither Run=0 nor vsync is taking the FSM out of capture.
    in_line   = (state_q == StCapture) && (state_d == StCapture);
    byte_stb  = in_line && pix_stb && s_href;
    line_end  = in_line && pix_stb && href_prev_q && !s_href;
    row_ok    = row_q < VLim;
    col_ok    = col_q < HLim;
    write_due = byte_stb && phase_q && row_ok && col_ok;
    pixel     = {hi_q, s_data};
    pixel_out = pixel;
    unique case (Mode)
      2'd0:    pixel_out = pixel;
      2'd1:    pixel_out = pixel ^ Key_data;
      2'd2:    pixel_out = (col_q >= {1'b0, Split_col}) ? (pixel ^ Key_data) : pixel;
      2'd3:    pixel_out = 16'h0000;
      default: pixel_out = pixel;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      pclk_prev_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      line_base_q  <= '0;
      wr_en_q      <= 1'b0;
      key_req_q    <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pix_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pclk_prev_q  <= s_pclk;
      wr_en_q      <= 1'b0;
      key_req_q    <= 1'b0;
      frame_done_q <= frame_end;
      if (pix_stb) href_prev_q <= s_href;

      if (enter_wait_hi) begin
        col_q       <= '0;
        row_q       <= '0;
        phase_q     <= 1'b0;
        line_base_q <= '0;
        pix_count_q <= '0;
        line_err_q  <= 1'b0;
      end else if (frame_end) begin
        // A half-assembled pixel at frame end is simply dropped, not flagged.
        col_q       <= '0;
        row_q       <= '0;
        phase_q     <= 1'b0;
        line_base_q <= '0;
        pix_count_q <= '0;
      end else begin
        if (byte_stb) begin
          if (!phase_q) begin
            hi_q      <= s_data;
            phase_q   <= 1'b1;
            key_req_q <= row_ok;
          end else begin
            phase_q <= 1'b0;
            if (col_q != 11'h7FF) col_q <= col_q + 11'd1;
            if (!col_ok) line_err_q <= 1'b1;
            if (write_due) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= line_base_q + ADDR_W'(col_q);
              wr_data_q <= pixel_out;
              if (pix_count_q != 20'hFFFFF) pix_count_q <= pix_count_q + 20'd1;
            end
          end
        end
        if (line_end) begin
          if (col_q != '0) begin
            col_q <= '0;
            if (row_q != 16'hFFFF) row_q <= row_q + 16'd1;
            if (row_ok) line_base_q <= line_base_q + HStep;
          end
          if (phase_q) begin
            phase_q    <= 1'b0;
            line_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign Key_req    = key_req_q;
  assign Wr_en      = wr_en_q;
  assign Wr_addr    = wr_addr_q;
  assign Wr_data    = wr_data_q;
  assign Frame_done = frame_done_q;
  assign Line_err   = line_err_q;
  assign Pix_count  = pix_count_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture on a reduced 8x4 geometry with a byte-level camera model.
module tb_cam_frame_capture;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned AW = 6;

  logic          Clk = 1'b0;
  logic          Reset, Run;
  logic          Cam_pclk, Cam_vsync, Cam_href;
  logic [7:0]    Cam_data;
  logic [1:0]    Mode;
  logic [9:0]    Split_col;
  logic [15:0]   Key_data;
  logic          Key_req, Wr_en, Frame_done, Line_err;
  logic [AW-1:0] Wr_addr;
  logic [15:0]   Wr_data;
  logic [19:0]   Pix_count;

  int checks = 0;
  int failures = 0;

  int wr_cnt = 0;
  int kr_cnt = 0;
  int fd_cnt = 0;
  logic [AW-1:0] log_addr [512];
  logic [15:0]   log_data [512];

  cam_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Cam_pclk(Cam_pclk), .Cam_vsync(Cam_vsync),
    .Cam_href(Cam_href), .Cam_data(Cam_data), .Mode(Mode), .Split_col(Split_col),
    .Key_data(Key_data), .Key_req(Key_req), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
    .Wr_data(Wr_data), .Frame_done(Frame_done), .Line_err(Line_err), .Pix_count(Pix_count)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Wr_en) begin
      if (wr_cnt < 512) begin
        log_addr[wr_cnt] = Wr_addr;
        log_data[wr_cnt] = Wr_data;
      end
      wr_cnt++;
    end
    if (Key_req) kr_cnt++;
    if (Frame_done) fd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    Cam_data = b;
    Cam_pclk = 1'b0;
    clk_n(2);
    Cam_pclk = 1'b1;
    clk_n(2);
  endtask

  task automatic idle_pclk(input int n);
    for (int i = 0; i < n; i++) send_byte(Cam_data);
  endtask

  task automatic vsync_pulse();
    Cam_vsync = 1'b1;
    idle_pclk(3);
    Cam_vsync = 1'b0;
    idle_pclk(3);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
    Cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) send_byte((i % 2 == 0) ? hi : lo);
    Cam_href = 1'b0;
    idle_pclk(2);
  endtask

  task automatic toggle_run();
    Run = 1'b0;
    clk_n(3);
    Run = 1'b1;
    clk_n(3);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0;
    Cam_pclk = 1'b0; Cam_vsync = 1'b0; Cam_href = 1'b0; Cam_data = 8'h00;
    Mode = 2'd0; Split_col = 10'd0; Key_data = 16'h0000;
    clk_n(4);
    checks++;
    if ({Wr_en, Key_req, Frame_done, Line_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=0000", {Wr_en, Key_req, Frame_done, Line_err});
    end
    checks++;
    if (Wr_addr !== '0 || Wr_data !== 16'h0 || Pix_count !== 20'h0) begin
      failures++;
      $display("FAIL reset_values addr=%h data=%h pix=%h want 0", Wr_addr, Wr_data, Pix_count);
    end
    Reset = 1'b0;
    Run = 1'b1;
    clk_n(3);
  endtask

  task automatic test_frame();
    int b, k, f;
    b = wr_cnt; k = kr_cnt; f = fd_cnt;
    vsync_pulse();
    for (int r = 0; r < int'(V); r++) send_line(2 * H, 8'hF8, 8'h00);
    checks++;
    if (wr_cnt - b !== 32) begin
      failures++; $display("FAIL frame_writes got=%0d want=32", wr_cnt - b);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (log_addr[b+i] !== AW'(i) || log_data[b+i] !== 16'hF800) begin
        failures++;
        $display("FAIL frame_pix[%0d] addr=%0d data=%h want addr=%0d data=f800",
                 i, log_addr[b+i], log_data[b+i], i);
      end
    end
    checks++;
    if (kr_cnt - k !== 32) begin
      failures++; $display("FAIL frame_keyreq got=%0d want=32", kr_cnt - k);
    end
    checks++;
    if (Pix_count !== 20'd32 || Line_err !== 1'b0) begin
      failures++; $display("FAIL frame_status pix=%0d err=%b want 32/0", Pix_count, Line_err);
    end
    vsync_pulse();
    checks++;
    if (fd_cnt - f !== 1) begin
      failures++; $display("FAIL frame_done got=%0d want=1", fd_cnt - f);
    end
    checks++;
    if (Pix_count !== 20'd0) begin
      failures++; $display("FAIL frame_pix_clear got=%0d want=0", Pix_count);
    end
  endtask

  task automatic test_modes();
    int b;
    logic [15:0] exp;
    b = wr_cnt;
    Mode = 2'd2; Split_col = 10'd4; Key_data = 16'hFFFF;
    send_line(2 * H, 8'h12, 8'h34);
    Mode = 2'd1; Key_data = 16'h0F0F;
    send_line(2 * H, 8'h12, 8'h34);
    Mode = 2'd3;
    send_line(2 * H, 8'h12, 8'h34);
    Mode = 2'd0;
    send_line(2 * H, 8'h12, 8'h34);
    checks++;
    if (wr_cnt - b !== 32) begin
      failures++; $display("FAIL modes_writes got=%0d want=32", wr_cnt - b);
    end
    for (int i = 0; i < 32; i++) begin
      if (i < 4) exp = 16'h1234;
      else if (i < 8) exp = 16'hEDCB;
      else if (i < 16) exp = 16'h1D3B;
      else if (i < 24) exp = 16'h0000;
      else exp = 16'h1234;
      checks++;
      if (log_data[b+i] !== exp || log_addr[b+i] !== AW'(i)) begin
        failures++;
        $display("FAIL modes_pix[%0d] addr=%0d data=%h want addr=%0d data=%h",
                 i, log_addr[b+i], log_data[b+i], i, exp);
      end
    end
    vsync_pulse();
  endtask

  task automatic test_overlong();
    int b;
    b = wr_cnt;
    send_line(2 * (H + 2), 8'hA1, 8'hB2);
    send_line(2 * H, 8'hA1, 8'hB2);
    checks++;
    if (wr_cnt - b !== 16) begin
      failures++; $display("FAIL overlong_writes got=%0d want=16", wr_cnt - b);
    end
    checks++;
    if (log_addr[b+7] !== AW'(7) || log_addr[b+8] !== AW'(8)) begin
      failures++;
      $display("FAIL overlong_addr a7=%0d a8=%0d want 7/8", log_addr[b+7], log_addr[b+8]);
    end
    checks++;
    if (Line_err !== 1'b1 || Pix_count !== 20'd16) begin
      failures++; $display("FAIL overlong_status err=%b pix=%0d want 1/16", Line_err, Pix_count);
    end
    vsync_pulse();
    checks++;
    if (Line_err !== 1'b1) begin
      failures++; $display("FAIL overlong_sticky err=%b want 1", Line_err);
    end
    toggle_run();
    checks++;
    if (Line_err !== 1'b0) begin
      failures++; $display("FAIL err_clear err=%b want 0", Line_err);
    end
  endtask

  task automatic test_odd_bytes();
    int b, k;
    vsync_pulse();
    b = wr_cnt; k = kr_cnt;
    send_line(3, 8'h11, 8'h22);
    checks++;
    if (Line_err !== 1'b1) begin
      failures++; $display("FAIL odd_err err=%b want 1", Line_err);
    end
    Cam_href = 1'b1;
    for (int i = 0; i < int'(H); i++) begin
      send_byte(8'h44);
      send_byte(8'h55);
    end
    Cam_href = 1'b0;
    idle_pclk(2);
    checks++;
    if (wr_cnt - b !== 9) begin
      failures++; $display("FAIL odd_writes got=%0d want=9", wr_cnt - b);
    end
    checks++;
    if (log_addr[b] !== AW'(0) || log_data[b] !== 16'h1122) begin
      failures++; $display("FAIL odd_first addr=%0d data=%h want 0/1122", log_addr[b], log_data[b]);
    end
    checks++;
    if (log_addr[b+1] !== AW'(8) || log_data[b+1] !== 16'h4455) begin
      failures++;
      $display("FAIL odd_realign addr=%0d data=%h want 8/4455", log_addr[b+1], log_data[b+1]);
    end
    checks++;
    if (kr_cnt - k !== 10) begin
      failures++; $display("FAIL odd_keyreq got=%0d want=10", kr_cnt - k);
    end
    vsync_pulse();
    toggle_run();
  endtask

  task automatic test_extra_rows();
    int b, k, mid;
    vsync_pulse();
    b = wr_cnt; k = kr_cnt;
    for (int r = 0; r < int'(V); r++) send_line(2 * H, 8'h0A, 8'h0B);
    mid = wr_cnt;
    send_line(2 * H, 8'h0A, 8'h0B);
    send_line(2 * H, 8'h0A, 8'h0B);
    checks++;
    if (wr_cnt !== mid || wr_cnt - b !== 32) begin
      failures++; $display("FAIL rows_extra_writes got=%0d want=32 total", wr_cnt - b);
    end
    checks++;
    if (log_addr[b+31] !== AW'(31)) begin
      failures++; $display("FAIL rows_last_addr got=%0d want=31", log_addr[b+31]);
    end
    checks++;
    if (kr_cnt - k !== 32 || Line_err !== 1'b0) begin
      failures++; $display("FAIL rows_keyreq got=%0d err=%b want 32/0", kr_cnt - k, Line_err);
    end
    vsync_pulse();
  endtask

  task automatic test_reset_mid_line();
    int b;
    send_line(2 * H, 8'h33, 8'h44);
    Cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h33);
      send_byte(8'h44);
    end
    clk_n(4);
    checks++;
    if (Pix_count !== 20'd12 || Wr_addr !== AW'(11)) begin
      failures++; $display("FAIL pre_reset pix=%0d addr=%0d want 12/11", Pix_count, Wr_addr);
    end
    Reset = 1'b1;
    clk_n(1);
    checks++;
    if (Pix_count !== 20'd0 || Wr_addr !== '0 || Wr_data !== 16'h0 ||
        {Wr_en, Key_req, Frame_done, Line_err} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset pix=%0d addr=%0d data=%h want all 0", Pix_count, Wr_addr, Wr_data);
    end
    Reset = 1'b0;
    b = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h33);
      send_byte(8'h44);
    end
    Cam_href = 1'b0;
    idle_pclk(2);
    send_line(2 * H, 8'h33, 8'h44);
    checks++;
    if (wr_cnt !== b) begin
      failures++; $display("FAIL no_capture_before_vsync got=%0d want=0", wr_cnt - b);
    end
    vsync_pulse();
    send_line(2 * H, 8'h56, 8'h78);
    checks++;
    if (wr_cnt - b !== 8 || log_addr[b] !== AW'(0) || log_data[b] !== 16'h5678) begin
      failures++;
      $display("FAIL resume n=%0d addr=%0d data=%h want 8/0/5678", wr_cnt - b, log_addr[b],
               log_data[b]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_modes();
    test_overlong();
    test_odd_bytes();
    test_extra_rows();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
